// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and the default bit period.
package uart_pkg;

    // 100 MHz system clock / 9600 baud
    localparam int BAUD_DIV_DEFAULT = 10416;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1, ticks on the last count and wraps.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_word.sv
// 8N1 transmitter for a 32-bit word: sends NBYTES bytes, byte 0 first, LSB first.
//
//   state | meaning
//   IDLE  | line high, waiting for send
//   START | start bit (tx=0) for one bit period
//   DATA  | 8 data bits of the current byte, LSB first
//   STOP  | stop bit (tx=1) for one bit period
//   NEXT  | one cycle: advance to next byte, or pulse done and return to IDLE
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int NBYTES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        hold_ctrl
);
    localparam int BW = $clog2(NBYTES + 1);

    tx_state_t     state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          baud_clear;
    logic          baud_tick;
    logic [7:0]    cur_byte;

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    assign cur_byte  = shift_q[7:0];
    assign busy      = (state_q != IDLE);
    assign hold_ctrl = busy;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        tx         = 1'b1;
        done       = 1'b0;
        baud_clear = 1'b1;

        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d = START;
                    shift_d = data_in;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                tx         = 1'b0;
                baud_clear = 1'b0;
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx         = cur_byte[bit_q];
                baud_clear = 1'b0;
                if (baud_tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                baud_clear = 1'b0;
                if (baud_tick) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // baud timer is held clear here so the next start bit begins at count 0
                shift_d = {8'h00, shift_q[31:8]};
                byte_d  = byte_q + BW'(1);
                if (byte_d == BW'(NBYTES)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = START;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: doc/uart_tx_word.md
UART_TX_WORD -- requirements
Module: uart_tx_word

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10416, clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter NBYTES, default 4, bytes sent per word (legal 1..4).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-005 SHALL have port data_in  input  32  word to transmit; byte 0 = data_in[7:0].
REQ-006 SHALL have port send  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port tx  output  1  serial line, idle high, 8N1 framing.
REQ-008 SHALL have port busy  output  1  high from the cycle after send is accepted until the cycle done pulses, inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last stop bit of the word.
REQ-010 SHALL have port hold_ctrl  output  1  equals busy; drives the data register's hold input so its OUT is frozen during transmission.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, NEXT.
REQ-012 In IDLE with send=1, SHALL latch data_in into a 32-bit shift register, clear byte and bit counters, enter START; tx goes low on the following cycle.
REQ-013 START SHALL hold tx=0 for exactly BAUD_DIV cycles, then enter DATA.
REQ-014 DATA SHALL drive the current byte LSB first, each bit for BAUD_DIV cycles, 8 bits, then enter STOP.
REQ-015 STOP SHALL hold tx=1 for BAUD_DIV cycles, then enter NEXT.
REQ-016 NEXT (1 cycle, tx=1) SHALL shift the word right by 8 and increment the byte counter; if byte counter reaches NBYTES, pulse done and return to IDLE, else enter START.
REQ-017 Word duration SHALL be NBYTES*(10*BAUD_DIV+1) cycles from the first low tx cycle to the done pulse inclusive.
REQ-018 Baud counter SHALL count 0..BAUD_DIV-1 and wrap to 0 on every state-bit boundary; no drift across bytes.
REQ-019 send SHALL be ignored while busy=1; data_in changes during busy SHALL NOT affect the frame.
REQ-020 send held high continuously SHALL start a new word on the cycle after done (the cycle the FSM is back in IDLE), giving back-to-back words separated by one idle-high cycle.
REQ-021 done and a new acceptance SHALL never occur in the same cycle.
REQ-022 Bit counter width SHALL be 3 bits, byte counter width $clog2(NBYTES+1); baud counter width $clog2(BAUD_DIV).

Reset
REQ-023 On rst=0, SHALL set state=IDLE, tx=1, busy=0, done=0, hold_ctrl=0, all counters and the shift register to 0.
REQ-024 Reset mid-frame SHALL abort immediately; tx returns high the next cycle with no done pulse.
REQ-025 send asserted on the same edge rst is low SHALL be ignored.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type (tx_state_t) and the default BAUD_DIV constant, shared with the receive side.
REQ-027 Baud timing SHALL be a sub-module uart_baud_gen (inputs clk, rst, clear; output tick when count = BAUD_DIV-1).
REQ-028 The top SHALL contain the FSM, shift register and counters only; no latches, single always_ff for state.

Verification (BAUD_DIV=4, NBYTES=4 unless noted)
REQ-029 Reset: rst=0 for 3 cycles with send=1 -> tx=1, busy=0, done=0 throughout and 1 cycle after release.
REQ-030 Single word: data_in=32'hA5C3_0F81, send pulse -> byte order 81,0F,C3,A5; first frame bits 0,1,0,0,0,0,0,0,1,1 each 4 cycles; done at cycle 164 after first low tx.
REQ-031 Ignore-while-busy: send pulse with 32'h0000_00FF, then send with 32'h1234_5678 at cycle 20 -> only FF,00,00,00 transmitted, one done pulse.
REQ-032 Back-to-back: send held high, data_in=32'h5555_5555 -> two words, exactly one tx-high cycle (IDLE) between second-word start and first done.
REQ-033 Abort: rst=0 at cycle 50 of a frame -> tx=1 next cycle, no done pulse, next send transmits a full clean frame.
REQ-034 NBYTES=1: data_in=32'hFFFF_FF00 -> single frame 0x00, done at cycle 41, busy low the cycle after.
